// File: rtl/fadd_norm_round.sv
// FP32 adder post-add stage: normalize, round-to-nearest-even, pack.
// Define FADD_NORM_LZC_EN for a single-cycle leading-zero normalize shift.
module fadd_norm_round #(
  parameter bit DENORM_FLUSH = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] cal_frac,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sign;
  logic [9:0]  r_exp;
  logic [26:0] r_frac;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_ovf;
  logic        r_valid;

  logic        w_acc;
  logic        w_xfer;
  logic [26:0] w_sh_frac;
  logic [9:0]  w_sh_exp;
  logic        w_sh_stop;

  logic [23:0] w_mant;
  logic        w_inc;
  logic [24:0] w_rsum;
  logic [9:0]  w_rexp;
  logic        w_norm;
  logic [7:0]  w_field;
  logic [22:0] w_frac23;
  logic        w_ovf;
  logic [31:0] w_pack;
  logic        w_pzero;

  assign w_acc  = in_valid & (r_state == IDLE);
  assign w_xfer = r_valid & out_ready;

`ifdef FADD_NORM_LZC_EN
  logic [4:0] w_lzc;
  logic [9:0] w_amt;

  // Leading-zero count over the hidden bit and fraction/GRS bits
  always_comb begin
    w_lzc = 5'd27;
    for (int i = 0; i <= 26; i++)
      if (r_frac[i]) w_lzc = 5'(26 - i);
  end

  assign w_amt = ({5'd0, w_lzc} < (r_exp - 10'd1)) ?
                 {5'd0, w_lzc} : (r_exp - 10'd1);
  assign w_sh_frac = r_frac << w_amt;
  assign w_sh_exp  = r_exp - w_amt;
  assign w_sh_stop = 1'b1;
`else
  logic w_at_min;

  // One-bit normalize step; never shift once exponent bottoms at 1
  always_comb begin
    w_at_min  = (r_exp == 10'd1);
    w_sh_frac = w_at_min ? r_frac : {r_frac[25:0], 1'b0};
    w_sh_exp  = w_at_min ? r_exp : (r_exp - 10'd1);
    w_sh_stop = w_sh_frac[26] | (w_sh_exp == 10'd1);
  end
`endif

  // Round-to-nearest-even and IEEE packing
  always_comb begin
    w_mant   = r_frac[26:3];
    w_inc    = r_frac[2] & ((|r_frac[1:0]) | w_mant[0]);
    w_rsum   = {1'b0, w_mant} + {24'd0, w_inc};
    w_rexp   = r_exp + {9'd0, w_rsum[24]};
    w_norm   = w_rsum[24] | w_rsum[23];
    w_field  = w_norm ? w_rexp[7:0] : 8'd0;
    w_frac23 = w_rsum[24] ? 23'd0 : w_rsum[22:0];
    w_ovf    = w_norm & (w_rexp >= 10'd255);
    w_pack   = {r_sign, w_field, w_frac23};
    if (w_ovf)
      w_pack = {r_sign, 8'hFF, 23'd0};
    else if (DENORM_FLUSH && (w_field == 8'd0))
      w_pack = {r_sign, 31'd0};
    w_pzero = (w_pack[30:0] == 31'd0);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          unique case (1'b1)
            (cal_frac == 28'd0):          w_next = DONE;
            (cal_frac[27] | cal_frac[26]): w_next = ROUND;
            default:                      w_next = SHIFT;
          endcase
        end
      end
      SHIFT: if (w_sh_stop) w_next = ROUND;
      ROUND: w_next = DONE;
      DONE:  if (w_xfer) w_next = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign   <= 1'b0;
      r_exp    <= 10'd0;
      r_frac   <= 27'd0;
      r_result <= 32'd0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= (r_state == DONE) & ~w_xfer;
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_sign <= in_sign;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
            unique case (1'b1)
              (cal_frac == 28'd0): begin
                r_sign   <= 1'b0;
                r_exp    <= {2'b00, in_exp};
                r_frac   <= 27'd0;
                r_result <= 32'd0;
                r_zero   <= 1'b1;
              end
              cal_frac[27]: begin
                r_exp  <= {2'b00, in_exp} + 10'd1;
                r_frac <= {cal_frac[27:2], cal_frac[1] | cal_frac[0]};
              end
              default: begin
                r_exp  <= {2'b00, in_exp};
                r_frac <= cal_frac[26:0];
              end
            endcase
          end
        end
        SHIFT: begin
          r_frac <= w_sh_frac;
          r_exp  <= w_sh_exp;
        end
        ROUND: begin
          r_result <= w_pack;
          r_zero   <= w_pzero;
          r_ovf    <= w_ovf;
        end
        DONE: ;
      endcase
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = r_valid;
  assign out_result   = r_result;
  assign out_zero     = r_zero;
  assign out_overflow = r_ovf;

endmodule

// File: tb/tb_fadd_norm_round.sv
// Scoreboard bench for fadd_norm_round: directed vectors,
// latency, backpressure and mid-operation reset.
module tb_fadd_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = 8'd0;
  logic [27:0] cal_frac = 28'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;

  fadd_norm_round dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .cal_frac     (cal_frac),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_overflow (out_overflow)
  );

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    int          lat;
  } exp_t;

`ifdef FADD_NORM_LZC_EN
  localparam int L_SUB = 3;
  localparam int L_DEN = 3;
`else
  localparam int L_SUB = 4;
  localparam int L_DEN = 4;
`endif

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc = 0;
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: latency on rising valid, data on each handshake
  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got out_valid=1, expected 0");
      end else begin
        chk("latency", 32'(cyc - acc), 32'(q[0].lat));
      end
    end
    if (out_valid && out_ready && q.size() != 0) begin
      e = q.pop_front();
      chk("result", out_result, e.res);
      chk("zero", {31'd0, out_zero}, {31'd0, e.zero});
      chk("overflow", {31'd0, out_overflow}, {31'd0, e.ovf});
    end
    prev_v = out_valid;
  end

  task automatic send(bit push, logic s, logic [7:0] ex,
                      logic [27:0] f, logic [31:0] r,
                      logic z, logic o, int lat);
    int   n = 0;
    exp_t x;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
      return;
    end
    in_sign  = s;
    in_exp   = ex;
    cal_frac = f;
    in_valid = 1'b1;
    if (push) begin
      x.res  = r;
      x.zero = z;
      x.ovf  = o;
      x.lat  = lat;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0",
               q.size());
      q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_zero", {31'd0, out_zero}, 32'd0);
    chk("rst_ovf", {31'd0, out_overflow}, 32'd0);
    rst = 1'b0;

    send(1, 0, 8'd127, 28'h8000000, 32'h40000000, 0, 0, 2);
    send(1, 0, 8'd127, 28'h1000000, 32'h3E800000, 0, 0, L_SUB);
    send(1, 0, 8'd127, 28'h4000004, 32'h3F800000, 0, 0, 2);
    send(1, 0, 8'd127, 28'h400000C, 32'h3F800002, 0, 0, 2);
    send(1, 1, 8'd127, 28'h0000000, 32'h00000000, 1, 0, 1);
    send(1, 0, 8'd254, 28'h8000000, 32'h7F800000, 0, 1, 2);
    send(1, 0, 8'd127, 28'h7FFFFFC, 32'h40000000, 0, 0, 2);
    send(1, 1, 8'd1,   28'h2000000, 32'h80400000, 0, 0, 3);
    send(1, 0, 8'd3,   28'h0400000, 32'h00200000, 0, 0, L_DEN);
    send(1, 0, 8'd1,   28'h3FFFFFC, 32'h00800000, 0, 0, 3);
    send(1, 0, 8'd127, 28'h8000009, 32'h40000001, 0, 0, 2);
    send(1, 1, 8'd130, 28'h6000000, 32'hC1400000, 0, 0, 2);
    drain();

    out_ready = 1'b0;
    send(1, 0, 8'd127, 28'h8000000, 32'h40000000, 0, 0, 2);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", out_result, 32'h40000000);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    send(0, 0, 8'd127, 28'h1000000, 32'h0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    send(1, 0, 8'd127, 28'h8000000, 32'h40000000, 0, 0, 2);
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
